// File: rtl/mem_access_unit_pkg.sv
// Shared MEM-stage definitions: write-back select encodings, FSM states, timeout default.
package mem_access_unit_pkg;

   localparam int unsigned TIMEOUT_DEFAULT = 16;
   localparam int unsigned XLEN            = 32;

   localparam logic [1:0] WB_ALU = 2'b00;
   localparam logic [1:0] WB_MEM = 2'b01;
   localparam logic [1:0] WB_LUI = 2'b10;
   localparam logic [1:0] WB_PC4 = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Write-back source mux keyed by the DatatoReg field.
   function automatic logic [XLEN-1:0] wb_select(
      input logic [1:0]      sel,
      input logic [XLEN-1:0] alu,
      input logic [XLEN-1:0] mem,
      input logic [XLEN-1:0] lui,
      input logic [XLEN-1:0] pc4
   );
      logic [XLEN-1:0] res;
      res = alu;
      case (sel)
         WB_ALU:  res = alu;
         WB_MEM:  res = mem;
         WB_LUI:  res = lui;
         WB_PC4:  res = pc4;
         default: res = alu;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/mem_access_unit_timer.sv
// Clearable saturating wait counter; terminal count flags the last allowed wait cycle.
module mem_wait_timer #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_tc_c
);

   localparam int unsigned     CNT_W  = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_cnt <= '0;
      end else if (i_en && (r_cnt != TC_VAL)) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign o_tc_c = (r_cnt == TC_VAL);

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access controller: req/ack handshake, pipeline stall,
// write-back selection and sticky misalign/timeout error flags.
module mem_access_unit #(
   parameter int unsigned TIMEOUT = mem_access_unit_pkg::TIMEOUT_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MEM_MemWrite,
   input  logic [1:0]  MEM_DatatoReg,
   input  logic        MEM_RegWrite,
   input  logic [4:0]  MEM_Rdes,
   input  logic [31:0] MEM_Res,
   input  logic [31:0] MEM_RDataB,
   input  logic [31:0] MEM_LuiData,
   input  logic [31:0] MEM_PCFour,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        mem_stall,
   output logic [31:0] wb_data,
   output logic [4:0]  wb_rdes,
   output logic        wb_regwrite,
   output logic        err_misalign,
   output logic        err_timeout
);
   import mem_access_unit_pkg::*;

   state_e      r_state;
   logic        r_fault;
   logic        r_err_misalign;
   logic        r_err_timeout;
   logic [31:0] r_load_q;

   logic w_mem_op;
   logic w_aligned;
   logic w_is_idle;
   logic w_is_wait;
   logic w_is_done;
   logic w_tc;

   assign w_mem_op  = MEM_MemWrite | (MEM_DatatoReg == WB_MEM);
   assign w_aligned = (MEM_Res[1:0] == 2'b00);
   assign w_is_idle = (r_state == ST_IDLE);
   assign w_is_wait = (r_state == ST_WAIT);
   assign w_is_done = (r_state == ST_DONE);

   // Counter holds zero outside WAIT so every access starts its wait window fresh.
   mem_wait_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .i_clr  (~w_is_wait),
      .i_en   (w_is_wait & ~dmem_ack),
      .o_tc_c (w_tc)
   );

   // Access sequencing; acks outside WAIT are deliberately ignored.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= ST_IDLE;
         r_fault        <= 1'b0;
         r_err_misalign <= 1'b0;
         r_err_timeout  <= 1'b0;
         r_load_q       <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_mem_op) begin
                  if (w_aligned) begin
                     r_state <= ST_WAIT;
                  end else begin
                     r_err_misalign <= 1'b1;
                     r_fault        <= 1'b1;
                     r_state        <= ST_DONE;
                  end
               end
            end
            ST_WAIT: begin
               if (dmem_ack) begin
                  r_load_q <= dmem_rdata;
                  r_state  <= ST_DONE;
               end else if (w_tc) begin
                  r_err_timeout <= 1'b1;
                  r_fault       <= 1'b1;
                  r_load_q      <= '0;
                  r_state       <= ST_DONE;
               end
            end
            ST_DONE: begin
               r_fault <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_fault <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Request and stall react in the arrival cycle, then follow the registered state.
   assign dmem_req   = (w_is_idle & w_mem_op & w_aligned) | w_is_wait;
   assign mem_stall  = (w_is_idle & w_mem_op) | w_is_wait;
   assign dmem_we    = MEM_MemWrite;
   assign dmem_addr  = {MEM_Res[31:2], 2'b00};
   assign dmem_wdata = MEM_RDataB;

   assign wb_data     = wb_select(MEM_DatatoReg, MEM_Res, r_load_q, MEM_LuiData, MEM_PCFour);
   assign wb_rdes     = MEM_Rdes;
   assign wb_regwrite = MEM_RegWrite & ~mem_stall & ~(w_is_done & r_fault);

   assign err_misalign = r_err_misalign;
   assign err_timeout  = r_err_timeout;

endmodule
